// File: rtl/riscv_pkg.sv
// Shared types for the execution-unit scheduler.
//   op_t        : decoded RV32I operation
//   idu_t       : decoded instruction record handed from the IDU
//   exu_class_t : target execution unit
//   exu_class() : maps an op to its execution unit
//   writes_rd() : true when the instruction produces a register result
package riscv_pkg;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK, OP_ILLEGAL
  } op_t;

  typedef struct packed {
    logic [63:0] seq;
    logic [31:0] pc;
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } idu_t;

  typedef enum logic [1:0] {EXU_ALU, EXU_CTL, EXU_LSU} exu_class_t;

  function automatic logic is_branch(op_t op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGE) ||
           (op == OP_BLTU) || (op == OP_BGEU);
  endfunction

  function automatic logic is_store(op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic exu_class_t exu_class(op_t op);
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR,
      OP_FENCE, OP_ECALL, OP_EBREAK, OP_ILLEGAL:      return EXU_CTL;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW:                            return EXU_LSU;
      default:                                        return EXU_ALU;
    endcase
  endfunction

  function automatic logic writes_rd(idu_t ins);
    return (ins.rd != 5'd0) && !is_branch(ins.op) && !is_store(ins.op) &&
           (ins.op != OP_FENCE);
  endfunction

endpackage

// File: rtl/riscv_exu_sched_fifo.sv
// Instruction queue for the scheduler: QDEPTH-entry FIFO of idu_t with a
// whole-queue flush.
//   clock, reset        : clock, synchronous active-high reset
//   push, push_data     : enqueue request and payload (dropped while flush)
//   pop                 : dequeue the head entry (ignored while flush)
//   flush, flush_seq    : discard every entry; flush_seq used only for checking
//   head_data           : current head entry
//   count, empty, full  : occupancy
import riscv_pkg::*;

module riscv_exu_sched_fifo #(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  idu_t                          push_data,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [63:0]                   flush_seq,
  output idu_t                          head_data,
  output logic [$clog2(QDEPTH):0]       count,
  output logic                          empty,
  output logic                          full
);

  localparam int unsigned PW = $clog2(QDEPTH);

  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;
  idu_t          mem_q [QDEPTH];
  logic          push_eff, pop_eff;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PW+1)'(QDEPTH));
  assign count     = count_q;
  assign head_data = mem_q[head_q];
  assign push_eff  = push & ~flush & ~full;
  assign pop_eff   = pop & ~flush & ~empty;

  // Pointers wrap naturally since QDEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_eff) tail_q <= tail_q + PW'(1);
      if (pop_eff)  head_q <= head_q + PW'(1);
      count_q <= count_q + (PW+1)'(push_eff) - (PW+1)'(pop_eff);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_eff) mem_q[tail_q] <= push_data;
  end

  // Everything thrown away by a flush must be younger than the redirect.
  for (genvar g = 0; g < QDEPTH; g++) begin : g_flush_chk
    logic [PW-1:0] offs;
    assign offs = PW'(g) - head_q;
    always_ff @(posedge clock) begin
      if (!reset && flush && ({1'b0, offs} < count_q)) assert (mem_q[g].seq >= flush_seq);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && flush && push) assert (push_data.seq >= flush_seq);
  end

endmodule

// File: rtl/riscv_exu_sched.sv
// In-order issue scheduler between the IDU and the ALU/CTL/LSU units.
//   clock, reset             : clock, synchronous active-high reset
//   idu_vld, idu, idu_rdy    : decoded instruction handshake into the queue
//   issue_idu                : instruction being issued (shared by all units)
//   alu_vld/ctl_vld/lsu_vld  : one-cycle issue pulses
//   alu_done/ctl_done/lsu_done : unit completion, clears the unit busy flag
//   wb_en, wb_rd             : register write-back, clears the scoreboard bit
//   flush, flush_seq         : redirect from CTL, empties the queue
//   stall_cycles             : saturating count of non-empty, non-issuing cycles
import riscv_pkg::*;

module riscv_exu_sched #(
  parameter int unsigned QDEPTH      = 2,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   idu_vld,
  input  idu_t                   idu,
  output logic                   idu_rdy,
  output idu_t                   issue_idu,
  output logic                   alu_vld,
  output logic                   ctl_vld,
  output logic                   lsu_vld,
  input  logic                   alu_done,
  input  logic                   ctl_done,
  input  logic                   lsu_done,
  input  logic                   wb_en,
  input  logic [4:0]             wb_rd,
  input  logic                   flush,
  input  logic [63:0]            flush_seq,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned PW = $clog2(QDEPTH);

  idu_t                   head;
  logic [PW:0]            q_count;
  logic                   q_empty, q_full, enq, issue;
  exu_class_t             cls;
  logic                   wr, hazard, unit_free;
  logic                   alu_free, ctl_free, lsu_free;

  logic [31:0]            sb_q, sb_d;
  logic                   alu_busy_q, ctl_busy_q, lsu_busy_q;
  logic                   alu_busy_d, ctl_busy_d, lsu_busy_d;
  logic                   alu_vld_q, ctl_vld_q, lsu_vld_q;
  idu_t                   issue_idu_q;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign idu_rdy = ~reset & ~q_full;
  assign enq     = idu_vld & idu_rdy;

  riscv_exu_sched_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (enq),
    .push_data (idu),
    .pop       (issue),
    .flush     (flush),
    .flush_seq (flush_seq),
    .head_data (head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  always_comb begin
    cls = exu_class(head.op);
    wr  = writes_rd(head);
    // A done in the decision cycle frees the unit for this decision.
    alu_free = ~alu_busy_q | alu_done;
    ctl_free = ~ctl_busy_q | ctl_done;
    lsu_free = ~lsu_busy_q | lsu_done;
    unit_free = 1'b0;
    case (cls)
      EXU_ALU: unit_free = alu_free;
      EXU_CTL: unit_free = ctl_free;
      EXU_LSU: unit_free = lsu_free;
      default: unit_free = 1'b0;
    endcase
    // x0 is never set in the scoreboard, so its bit reads as clear.
    hazard = sb_q[head.rs1] | sb_q[head.rs2] | (wr & sb_q[head.rd]);
    // ctl_free is the barrier: nothing issues while a control op is in flight.
    issue  = ~q_empty & ~flush & unit_free & ctl_free & ~hazard;
  end

  always_comb begin
    sb_d = sb_q;
    if (wb_en && (wb_rd != 5'd0)) sb_d[wb_rd] = 1'b0;
    if (issue && wr)              sb_d[head.rd] = 1'b1;  // set wins over clear
    alu_busy_d = (alu_busy_q & ~alu_done) | (issue & (cls == EXU_ALU));
    ctl_busy_d = (ctl_busy_q & ~ctl_done) | (issue & (cls == EXU_CTL));
    lsu_busy_d = (lsu_busy_q & ~lsu_done) | (issue & (cls == EXU_LSU));
    stall_d = stall_q;
    if (!q_empty && !issue && !(&stall_q)) stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_q        <= '0;
      alu_busy_q  <= 1'b0;
      ctl_busy_q  <= 1'b0;
      lsu_busy_q  <= 1'b0;
      alu_vld_q   <= 1'b0;
      ctl_vld_q   <= 1'b0;
      lsu_vld_q   <= 1'b0;
      issue_idu_q <= '0;
      stall_q     <= '0;
    end else begin
      sb_q       <= sb_d;
      alu_busy_q <= alu_busy_d;
      ctl_busy_q <= ctl_busy_d;
      lsu_busy_q <= lsu_busy_d;
      alu_vld_q  <= issue & (cls == EXU_ALU);
      ctl_vld_q  <= issue & (cls == EXU_CTL);
      lsu_vld_q  <= issue & (cls == EXU_LSU);
      if (issue) issue_idu_q <= head;
      stall_q    <= stall_d;
    end
  end

  assign alu_vld      = alu_vld_q;
  assign ctl_vld      = ctl_vld_q;
  assign lsu_vld      = lsu_vld_q;
  assign issue_idu    = issue_idu_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_riscv_exu_sched.sv
// Directed bench for riscv_exu_sched: a per-cycle vector table (inputs plus
// expected outputs for that cycle) and a short hand-written latency sequence.
import riscv_pkg::*;

module tb_riscv_exu_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        idu_vld = 1'b0;
  idu_t        idu = '0;
  logic        idu_rdy;
  idu_t        issue_idu;
  logic        alu_vld, ctl_vld, lsu_vld;
  logic        alu_done = 1'b0, ctl_done = 1'b0, lsu_done = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic [63:0] flush_seq = '0;
  logic [31:0] stall_cycles;

  always #5 clock = ~clock;

  riscv_exu_sched #(
    .QDEPTH      (2),
    .STALL_CNT_W (32)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .idu_vld      (idu_vld),
    .idu          (idu),
    .idu_rdy      (idu_rdy),
    .issue_idu    (issue_idu),
    .alu_vld      (alu_vld),
    .ctl_vld      (ctl_vld),
    .lsu_vld      (lsu_vld),
    .alu_done     (alu_done),
    .ctl_done     (ctl_done),
    .lsu_done     (lsu_done),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .flush_seq    (flush_seq),
    .stall_cycles (stall_cycles)
  );

  // One row per cycle. dn and e_v are {alu, ctl, lsu}. wbrd=0: no write-back,
  // fseq=0: no flush, e_stall<0: stall counter not checked that cycle.
  typedef struct {
    bit       rst;
    bit       vld;
    idu_t     ins;
    bit [2:0] dn;
    int       wbrd;
    int       fseq;
    bit       e_rdy;
    bit [2:0] e_v;
    int       e_seq;
    int       e_stall;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   failures = 0;

  function automatic idu_t mk(op_t op, int rd, int rs1, int rs2, int seq);
    idu_t r;
    r     = '0;
    r.op  = op;
    r.rd  = 5'(rd);
    r.rs1 = 5'(rs1);
    r.rs2 = 5'(rs2);
    r.seq = 64'(seq);
    r.pc  = 32'(seq) << 2;
    r.imm = 32'(seq);
    return r;
  endfunction

  task automatic add(int rst, int vld, op_t op, int rd, int rs1, int rs2, int seq,
                     bit [2:0] dn, int wbrd, int fseq, int e_rdy, bit [2:0] e_v,
                     int e_seq, int e_stall);
    vec_t v;
    v.rst     = (rst != 0);
    v.vld     = (vld != 0);
    v.ins     = mk(op, rd, rs1, rs2, seq);
    v.dn      = dn;
    v.wbrd    = wbrd;
    v.fseq    = fseq;
    v.e_rdy   = (e_rdy != 0);
    v.e_v     = e_v;
    v.e_seq   = e_seq;
    v.e_stall = e_stall;
    vq.push_back(v);
  endtask

  task automatic idle(bit [2:0] dn, int wbrd, int e_rdy, bit [2:0] e_v, int e_seq,
                      int e_stall);
    add(0, 0, OP_ADDI, 0, 0, 0, 0, dn, wbrd, 0, e_rdy, e_v, e_seq, e_stall);
  endtask

  task automatic check(string name, int row, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (row %0d): got %0d, expected %0d", name, row, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // ---- ADDI x1 -> ADD x2,x1,x1 RAW through write-back ----------------------
    add(1, 0, OP_ADDI, 0, 0, 0, 0,  3'b000, 0, 0, 0, 3'b000, 0, 0);   // c0 reset
    add(0, 1, OP_ADDI, 1, 0, 0, 1,  3'b000, 0, 0, 1, 3'b000, 0, 0);   // c1
    add(0, 1, OP_ADD,  2, 1, 1, 2,  3'b000, 0, 0, 1, 3'b000, 0, 0);   // c2
    idle(3'b000, 0, 1, 3'b100, 1, 0);                                 // c3 ADDI issued
    idle(3'b100, 0, 1, 3'b000, 0, 1);                                 // c4 alu done
    idle(3'b000, 1, 1, 3'b000, 0, 2);                                 // c5 wb x1
    idle(3'b000, 0, 1, 3'b000, 0, 3);                                 // c6
    idle(3'b000, 0, 1, 3'b100, 2, 3);                                 // c7 ADD issued
    idle(3'b100, 2, 1, 3'b000, 0, 3);                                 // c8
    // ---- BEQ barrier, flush with ctl_done, same-cycle enqueue dropped -------
    add(0, 1, OP_BEQ,  0, 1, 2, 10, 3'b000, 0, 0,  1, 3'b000, 0, 3);  // c9
    add(0, 1, OP_ADDI, 3, 0, 0, 11, 3'b000, 0, 0,  1, 3'b000, 0, 3);  // c10
    idle(3'b000, 0, 1, 3'b010, 10, 3);                                // c11 BEQ issued
    idle(3'b000, 0, 1, 3'b000, 0, 4);                                 // c12 held
    add(0, 1, OP_ADDI, 12, 0, 0, 12, 3'b010, 0, 11, 1, 3'b000, 0, 5); // c13 flush
    idle(3'b000, 0, 1, 3'b000, 0, 6);                                 // c14
    idle(3'b000, 0, 1, 3'b000, 0, 6);                                 // c15
    // ---- fill with busy ALU, then back-to-back issue via done bypass --------
    add(0, 1, OP_ADDI, 4, 0, 0, 20, 3'b000, 0, 0, 1, 3'b000, 0, 6);   // c16
    add(0, 1, OP_ADDI, 5, 0, 0, 21, 3'b000, 0, 0, 1, 3'b000, 0, 6);   // c17
    add(0, 1, OP_ADDI, 6, 0, 0, 22, 3'b000, 0, 0, 1, 3'b100, 20, 6);  // c18
    idle(3'b000, 0, 0, 3'b000, 0, 7);                                 // c19 full
    idle(3'b100, 0, 0, 3'b000, 0, 8);                                 // c20 done
    idle(3'b100, 0, 1, 3'b100, 21, 8);                                // c21 done again
    idle(3'b100, 4, 1, 3'b100, 22, 8);                                // c22 no bubble
    idle(3'b000, 6, 1, 3'b000, 0, 8);                                 // c23
    // ---- wb x5 clear coincides with issue of new x5 writer: set wins ------
    add(0, 1, OP_ADDI, 5, 0, 0, 30, 3'b000, 5, 0, 1, 3'b000, 0, 8);   // c24
    add(0, 1, OP_ADD,  7, 5, 0, 31, 3'b000, 5, 0, 1, 3'b000, 0, 8);   // c25
    idle(3'b100, 0, 1, 3'b100, 30, 8);                                // c26 reader blocked
    idle(3'b000, 0, 1, 3'b000, 0, 9);                                 // c27
    idle(3'b000, 5, 1, 3'b000, 0, 10);                                // c28 real wb x5
    idle(3'b000, 0, 1, 3'b000, 0, 11);                                // c29
    idle(3'b100, 7, 1, 3'b100, 31, 11);                               // c30
    // ---- reset with two queued entries and busy LSU -------------------------
    add(0, 1, OP_LW,   8, 0, 0, 40, 3'b000, 0, 0, 1, 3'b000, 0, 11);  // c31
    add(0, 1, OP_SW,   0, 0, 0, 41, 3'b000, 0, 0, 1, 3'b000, 0, 11);  // c32
    add(0, 1, OP_SW,   0, 0, 0, 42, 3'b000, 0, 0, 1, 3'b001, 40, 11); // c33
    add(1, 0, OP_ADDI, 0, 0, 0, 0,  3'b000, 0, 0, 0, 3'b000, 0, -1);  // c34 reset
    add(1, 0, OP_ADDI, 0, 0, 0, 0,  3'b000, 0, 0, 0, 3'b000, 0, 0);   // c35 reset
    idle(3'b001, 8, 1, 3'b000, 0, 0);                                 // c36 late done/wb
    add(0, 1, OP_LW,   9, 0, 0, 50, 3'b000, 0, 0, 1, 3'b000, 0, 0);   // c37
    idle(3'b000, 0, 1, 3'b000, 0, 0);                                 // c38
    idle(3'b001, 9, 1, 3'b001, 50, 0);                                // c39
    idle(3'b000, 0, 1, 3'b000, 0, 0);                                 // c40

    repeat (2) @(posedge clock);
    #1;
    foreach (vq[i]) begin
      reset     = vq[i].rst;
      idu_vld   = vq[i].vld;
      idu       = vq[i].ins;
      {alu_done, ctl_done, lsu_done} = vq[i].dn;
      wb_en     = (vq[i].wbrd != 0);
      wb_rd     = 5'(vq[i].wbrd);
      flush     = (vq[i].fseq != 0);
      flush_seq = 64'(vq[i].fseq);
      #1;
      check("idu_rdy", i, 64'(idu_rdy), 64'(vq[i].e_rdy));
      check("alu_vld", i, 64'(alu_vld), 64'(vq[i].e_v[2]));
      check("ctl_vld", i, 64'(ctl_vld), 64'(vq[i].e_v[1]));
      check("lsu_vld", i, 64'(lsu_vld), 64'(vq[i].e_v[0]));
      if (vq[i].e_v != 3'b000) check("issue_seq", i, issue_idu.seq, 64'(vq[i].e_seq));
      if (vq[i].e_stall >= 0) check("stall_cycles", i, 64'(stall_cycles), 64'(vq[i].e_stall));
      @(posedge clock);
      #1;
    end

    // ---- minimum enqueue-to-issue latency for a CTL op ----------------------
    {alu_done, ctl_done, lsu_done} = 3'b000;
    wb_en   = 1'b0;
    flush   = 1'b0;
    reset   = 1'b0;
    idu     = mk(OP_ECALL, 0, 0, 0, 60);
    idu_vld = 1'b1;
    @(posedge clock);
    #1;
    idu_vld = 1'b0;
    n = 1;
    while (!ctl_vld && n < 6) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("ecall_latency", 100, 64'(n), 64'd2);
    check("ecall_ctl_vld", 100, 64'(ctl_vld), 64'd1);
    check("ecall_seq", 100, issue_idu.seq, 64'd60);
    ctl_done = 1'b1;
    @(posedge clock);
    #1;
    ctl_done = 1'b0;
    check("ecall_pulse_len", 101, 64'(ctl_vld), 64'd0);
    check("ecall_stall", 101, 64'(stall_cycles), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_exu_sched.md
Name: riscv_exu_sched

Overview:
In-order issue scheduler between the IDU and the three execution units (ALU, CTL, LSU). It buffers decoded instructions and tracks pending register writes in a scoreboard. It dispatches one instruction per cycle to the target unit once that unit is free and all operands are hazard-free. It serializes behind control-flow ops so that a CTL flush never has younger instructions in flight.

Parameters:
QDEPTH, 2, instruction queue entries (power of 2, >=2)
STALL_CNT_W, 32, width of saturating stall-cycle counter

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
idu_vld  input  1  decoded instruction valid
idu  input  idu_t  decoded instruction
idu_rdy  output  1  queue can accept this cycle
issue_idu  output  idu_t  instruction being issued, shared by all units
alu_vld  output  1  issue pulse to ALU
ctl_vld  output  1  issue pulse to riscv_exu_ctl
lsu_vld  output  1  issue pulse to LSU
alu_done  input  1  ALU completed
ctl_done  input  1  CTL completed
lsu_done  input  1  LSU completed
wb_en  input  1  register write-back this cycle
wb_rd  input  5  write-back destination
flush  input  1  redirect from CTL
flush_seq  input  64  first sequence number to discard
stall_cycles  output  STALL_CNT_W  cycles with non-empty queue and no issue

Behaviour:
- Reset is synchronous and active-high on clock. While reset is high: queue empty, scoreboard 0, unit busy flags 0, alu/ctl/lsu_vld=0, issue_idu=0, idu_rdy=0, stall_cycles=0. idu_rdy=1 from the first cycle after reset.
- Queue is a FIFO with head/tail pointers (wrap mod QDEPTH) and a count. idu_rdy = (count != QDEPTH), taken from registered state. Enqueue on idu_vld && idu_rdy. Simultaneous enqueue and issue when full is not allowed; rdy is already low in that case.
- Unit class comes from the package function exu_class(idu.op):
  - BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR/FENCE/ECALL/EBREAK/ILLEGAL -> CTL
  - loads/stores -> LSU
  - everything else -> ALU
- writes_rd = (idu.rd != 0) && not branch, store or FENCE.
- Head issues in cycle N when all of the following hold:
  - queue is non-empty
  - target busy flag is 0
  - ctl_busy is 0 (speculation barrier)
  - scoreboard[rs1] and scoreboard[rs2] are 0 (x0 is never pending)
  - if writes_rd, scoreboard[rd] is 0 (WAW)
- Hazard checks use the registered scoreboard. A dependent instruction issues no earlier than the cycle after the matching wb_en.
- Issue is registered: in cycle N+1 the selected *_vld=1 for exactly one cycle and issue_idu holds the entry. Also in N+1: target busy set, scoreboard[rd] set if writes_rd, head pops.
- Minimum latency from enqueue to *_vld is 2 cycles (enqueue N, issue decision N+1, vld N+2).
- busy_x clears on x_done. If x_done arrives in the same cycle as a new issue decision for x, the issue is allowed: the done clear is bypassed into the busy check, and busy ends up set.
- Scoreboard bit clears on wb_en for wb_rd != 0. If a clear and a set hit the same register in the same cycle, set wins.
- Flush: all queue entries and any same-cycle enqueue are discarded, and no issue happens that cycle. Scoreboard and busy flags are untouched, since in-flight ops are older than flush_seq by the barrier. Assertion: every discarded entry has seq >= flush_seq.
- stall_cycles increments when the queue is non-empty and no issue happens. It saturates at all-ones.
- Reset mid-operation: all state clears regardless of outstanding done/wb. A late done or wb after reset is ignored; a busy flag that is already 0 stays 0.

Decomposition:
- riscv_pkg: exu_class_t enum {EXU_ALU, EXU_CTL, EXU_LSU}, functions exu_class(op_t) and writes_rd(idu_t).
- One sub-module: riscv_exu_sched_fifo (parameterized idu_t FIFO with flush-clear).

Test Plan:
- ADDI x1 then ADD x2,x1,x1 enqueued back-to-back; wb_en/wb_rd=1 in cycle 5 -> ADD alu_vld no earlier than cycle 6; stall_cycles counts the gap.
- BEQ followed by ADDI x3 -> ctl_vld pulses; ADDI is held until ctl_done. With flush=1 and flush_seq=BEQ.seq+1 alongside ctl_done -> queue empties, alu_vld never asserts for ADDI.
- Fill queue (QDEPTH=2) with a busy ALU -> idu_rdy=0 on the next cycle. alu_done -> one issue, idu_rdy=1 the cycle after.
- alu_done in the same cycle as the next ALU issue decision -> alu_vld pulses on consecutive issues with no bubble.
- wb clear of x5 in the same cycle as issue of a new writer to x5 -> scoreboard[5] stays 1, and a reader of x5 stays blocked.
- Assert reset with 2 queued entries and busy LSU -> all vld=0 and idu_rdy=0 during reset. A lsu_done arriving after reset changes nothing; the next LSU op issues immediately.
